// File: rtl/stream_pkg.sv
// stream_pkg: shared types and constants for the stream mux family.
//   state_t      - packet lock FSM encoding
//   SRC_0/SRC_1  - source index constants, also the select_o encoding
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_0 = 2'd1,
    LOCK_1 = 2'd2
  } state_t;

  localparam logic SRC_0 = 1'b0;
  localparam logic SRC_1 = 1'b1;

endpackage

// File: rtl/stream_mux_2_if.sv
// stream_mux_2_if: bundles the two source streams and the merged sink stream.
//   slave  - the mux side (sources in, sink out)
//   master - the producer/consumer side (drives sources, receives sink)
interface stream_mux_2_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_0_i;
  logic                  valid_0_i;
  logic                  last_0_i;
  logic                  ready_0_o;
  logic [DATA_WIDTH-1:0] data_1_i;
  logic                  valid_1_i;
  logic                  last_1_i;
  logic                  ready_1_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  last_o;
  logic                  select_o;
  logic                  ready_i;

  modport slave (
    input  data_0_i, valid_0_i, last_0_i,
    input  data_1_i, valid_1_i, last_1_i,
    input  ready_i,
    output ready_0_o, ready_1_o,
    output data_o, valid_o, last_o, select_o
  );

  modport master (
    output data_0_i, valid_0_i, last_0_i,
    output data_1_i, valid_1_i, last_1_i,
    output ready_i,
    input  ready_0_o, ready_1_o,
    input  data_o, valid_o, last_o, select_o
  );
endinterface

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-requester round-robin arbiter.
//   clk, rst - clock, synchronous active-high reset (prio back to SRC_0)
//   req      - request vector, bit x = requester x
//   upd      - advance the priority pointer past the current grant
//   gnt_vld  - some requester is granted
//   gnt      - index of the granted requester
module rr_arbiter_2
  import stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       gnt_vld,
  output logic       gnt
);

  logic prio;

  always_comb begin
    gnt_vld = |req;
    gnt     = SRC_0;
    if (&req)       gnt = prio;
    else if (req[1]) gnt = SRC_1;
  end

  // The winner drops to lowest priority once its grant is released.
  always_ff @(posedge clk) begin
    if (rst)      prio <= SRC_0;
    else if (upd) prio <= ~gnt;
  end

endmodule

// File: rtl/stream_mux_2.sv
// stream_mux_2: 2-to-1 valid/ready stream merger with a registered output.
//   clk_i    - clock
//   s_rst_i  - synchronous active-high reset
//   bus      - two source streams in, merged stream out (select_o = source)
// PKT_MODE=1 holds the grant from the first beat through the last beat of a
// packet; PKT_MODE=0 re-arbitrates on every beat.
module stream_mux_2
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_MODE   = 1
) (
  input  logic           clk_i,
  input  logic           s_rst_i,
  stream_mux_2_if.slave  bus
);

  state_t                state, state_nxt;
  logic                  load, xfer, rel;
  logic [1:0]            req;
  logic                  gnt_vld, gnt;
  logic [DATA_WIDTH-1:0] data_g;
  logic                  last_g;

  // Output stage can take a beat when empty or being drained this cycle.
  assign load = ~bus.valid_o | bus.ready_i;

  // A lock masks the other source out of arbitration entirely.
  always_comb begin
    req = {bus.valid_1_i, bus.valid_0_i};
    case (state)
      LOCK_0:  req[1] = 1'b0;
      LOCK_1:  req[0] = 1'b0;
      default: ;
    endcase
  end

  rr_arbiter_2 u_arb (
    .clk     (clk_i),
    .rst     (s_rst_i),
    .req     (req),
    .upd     (rel),
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

  // A grant implies the granted source is valid, so grant & load is a transfer.
  assign xfer   = load & gnt_vld & ~s_rst_i;
  assign data_g = (gnt == SRC_1) ? bus.data_1_i : bus.data_0_i;
  assign last_g = (gnt == SRC_1) ? bus.last_1_i : bus.last_0_i;
  assign rel    = xfer & ((PKT_MODE == 0) | last_g);

  assign bus.ready_0_o = xfer & (gnt == SRC_0);
  assign bus.ready_1_o = xfer & (gnt == SRC_1);

  always_ff @(posedge clk_i) begin
    if (s_rst_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Single-beat packets never leave IDLE.
  always_comb begin
    state_nxt = state;
    if ((PKT_MODE != 0) && xfer) begin
      case (state)
        IDLE:           if (!last_g) state_nxt = (gnt == SRC_1) ? LOCK_1 : LOCK_0;
        LOCK_0, LOCK_1: if (last_g)  state_nxt = IDLE;
        default:        state_nxt = IDLE;
      endcase
    end
  end

  // Idle cycles clear valid but keep the last beat's payload visible.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      bus.data_o   <= '0;
      bus.valid_o  <= 1'b0;
      bus.last_o   <= 1'b0;
      bus.select_o <= SRC_0;
    end else if (load) begin
      if (xfer) begin
        bus.data_o   <= data_g;
        bus.valid_o  <= 1'b1;
        bus.last_o   <= last_g;
        bus.select_o <= gnt;
      end else begin
        bus.valid_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_2.sv
// tb_stream_mux_2: bench for stream_mux_2. u_dut0 runs PKT_MODE=1, u_dut1
// runs PKT_MODE=0. Directed vectors from a table, a hand-written reset
// sequence, then random traffic against a transaction-level model.
module tb_stream_mux_2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stream_mux_2_if #(.DATA_WIDTH(8)) if0 ();
  stream_mux_2_if #(.DATA_WIDTH(8)) if1 ();

  stream_mux_2 #(.DATA_WIDTH(8), .PKT_MODE(1)) u_dut0 (.clk_i(clk), .s_rst_i(rst), .bus(if0));
  stream_mux_2 #(.DATA_WIDTH(8), .PKT_MODE(0)) u_dut1 (.clk_i(clk), .s_rst_i(rst), .bus(if1));

  // mode: 0 -> check u_dut0, 1 -> check u_dut1, 2 -> check both
  typedef struct {
    int         mode;
    logic       rst;
    logic       v0, l0;
    logic [7:0] d0;
    logic       v1, l1;
    logic [7:0] d1;
    logic       rdy;
    logic       er0, er1;
    logic       ev;
    logic [7:0] ed;
    logic       el, es;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int mode, input logic r,
                              input logic v0, input logic l0, input logic [7:0] d0,
                              input logic v1, input logic l1, input logic [7:0] d1,
                              input logic rdy, input logic er0, input logic er1,
                              input logic ev, input logic [7:0] ed, input logic el, input logic es);
    vec_t t;
    t.mode = mode; t.rst = r;
    t.v0 = v0; t.l0 = l0; t.d0 = d0;
    t.v1 = v1; t.l1 = l1; t.d1 = d1;
    t.rdy = rdy; t.er0 = er0; t.er1 = er1;
    t.ev = ev; t.ed = ed; t.el = el; t.es = es;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input int k, input logic v0, input logic l0, input logic [7:0] d0,
                     input logic v1, input logic l1, input logic [7:0] d1, input logic rdy);
    if (k == 0) begin
      if0.valid_0_i = v0; if0.last_0_i = l0; if0.data_0_i = d0;
      if0.valid_1_i = v1; if0.last_1_i = l1; if0.data_1_i = d1;
      if0.ready_i   = rdy;
    end else begin
      if1.valid_0_i = v0; if1.last_0_i = l0; if1.data_0_i = d0;
      if1.valid_1_i = v1; if1.last_1_i = l1; if1.data_1_i = d1;
      if1.ready_i   = rdy;
    end
  endtask

  task automatic chk_rdy(input int k, input string tag, input logic er0, input logic er1);
    if (k == 0) begin
      chk({tag, " dut0 ready_0"}, {31'd0, if0.ready_0_o}, {31'd0, er0});
      chk({tag, " dut0 ready_1"}, {31'd0, if0.ready_1_o}, {31'd0, er1});
    end else begin
      chk({tag, " dut1 ready_0"}, {31'd0, if1.ready_0_o}, {31'd0, er0});
      chk({tag, " dut1 ready_1"}, {31'd0, if1.ready_1_o}, {31'd0, er1});
    end
  endtask

  task automatic chk_out(input int k, input string tag, input logic ev,
                         input logic [7:0] ed, input logic el, input logic es);
    if (k == 0) begin
      chk({tag, " dut0 valid_o"},  {31'd0, if0.valid_o},  {31'd0, ev});
      chk({tag, " dut0 data_o"},   {24'd0, if0.data_o},   {24'd0, ed});
      chk({tag, " dut0 last_o"},   {31'd0, if0.last_o},   {31'd0, el});
      chk({tag, " dut0 select_o"}, {31'd0, if0.select_o}, {31'd0, es});
    end else begin
      chk({tag, " dut1 valid_o"},  {31'd0, if1.valid_o},  {31'd0, ev});
      chk({tag, " dut1 data_o"},   {24'd0, if1.data_o},   {24'd0, ed});
      chk({tag, " dut1 last_o"},   {31'd0, if1.last_o},   {31'd0, el});
      chk({tag, " dut1 select_o"}, {31'd0, if1.select_o}, {31'd0, es});
    end
  endtask

  // Drive one vector to both DUTs, check readies before the edge and the
  // registered outputs just after it. Called at posedge+1.
  task automatic apply(input vec_t t, input string tag);
    drv(0, t.v0, t.l0, t.d0, t.v1, t.l1, t.d1, t.rdy);
    drv(1, t.v0, t.l0, t.d0, t.v1, t.l1, t.d1, t.rdy);
    rst = t.rst;
    #1;
    for (int k = 0; k < 2; k++)
      if (t.mode == k || t.mode == 2) chk_rdy(k, tag, t.er0, t.er1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      if (t.mode == k || t.mode == 2) chk_out(k, tag, t.ev, t.ed, t.el, t.es);
  endtask

  // ---------------- random phase state ----------------
  logic       rv[2][2], rl[2][2];
  logic [7:0] rd[2][2];
  logic       rr[2];
  int         m_lock[2];   // -1: no packet open, else owning source
  int         m_prio[2];
  logic       m_v[2], m_l[2], m_s[2];
  logic [7:0] m_d[2];

  initial begin
    drv(0, 0, 0, 8'h00, 0, 0, 8'h00, 1);
    drv(1, 0, 0, 8'h00, 0, 0, 8'h00, 1);

    // reset hold with both sources valid
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(2, 1, 1,0,8'h55, 1,0,8'h66, 1, 0,0, 0,8'h00,0,0));
    // contention, packet mode
    tbl.push_back(mk(0, 0, 1,0,8'h10, 1,0,8'hA0, 1, 1,0, 1,8'h10,0,0));
    tbl.push_back(mk(0, 0, 1,0,8'h11, 1,0,8'hA0, 1, 1,0, 1,8'h11,0,0));
    tbl.push_back(mk(0, 0, 1,1,8'h12, 1,0,8'hA0, 1, 1,0, 1,8'h12,1,0));
    tbl.push_back(mk(0, 0, 0,0,8'h00, 1,0,8'hA0, 1, 0,1, 1,8'hA0,0,1));
    tbl.push_back(mk(0, 0, 0,0,8'h00, 1,1,8'hA1, 1, 0,1, 1,8'hA1,1,1));
    tbl.push_back(mk(0, 0, 0,0,8'h00, 0,0,8'h00, 1, 0,0, 0,8'hA1,1,1));
    // back-pressure mid-packet
    tbl.push_back(mk(0, 0, 1,0,8'h20, 1,0,8'hB0, 1, 1,0, 1,8'h20,0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 1,0,8'h21, 1,1,8'hB0, 0, 0,0, 1,8'h20,0,0));
    tbl.push_back(mk(0, 0, 1,0,8'h21, 1,1,8'hB0, 1, 1,0, 1,8'h21,0,0));
    tbl.push_back(mk(0, 0, 1,1,8'h22, 1,1,8'hB0, 1, 1,0, 1,8'h22,1,0));
    tbl.push_back(mk(0, 0, 0,0,8'h00, 1,1,8'hB0, 1, 0,1, 1,8'hB0,1,1));
    tbl.push_back(mk(0, 0, 0,0,8'h00, 0,0,8'h00, 1, 0,0, 0,8'hB0,1,1));
    // lock hold while owner drops valid
    tbl.push_back(mk(0, 0, 1,0,8'h30, 1,1,8'hC0, 1, 1,0, 1,8'h30,0,0));
    tbl.push_back(mk(0, 0, 0,0,8'h00, 1,1,8'hC0, 1, 0,0, 0,8'h30,0,0));
    tbl.push_back(mk(0, 0, 0,0,8'h00, 1,1,8'hC0, 1, 0,0, 0,8'h30,0,0));
    tbl.push_back(mk(0, 0, 1,1,8'h31, 1,1,8'hC0, 1, 1,0, 1,8'h31,1,0));
    tbl.push_back(mk(0, 0, 0,0,8'h00, 1,1,8'hC0, 1, 0,1, 1,8'hC0,1,1));
    tbl.push_back(mk(0, 0, 0,0,8'h00, 0,0,8'h00, 1, 0,0, 0,8'hC0,1,1));

    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // reset while dut0 is locked on source 1
    apply(mk(0, 0, 0,0,8'h00, 1,0,8'hD0, 1, 0,1, 1,8'hD0,0,1), "rstmid_a");
    apply(mk(0, 0, 1,1,8'hE0, 1,0,8'hD1, 1, 0,1, 1,8'hD1,0,1), "rstmid_b");
    apply(mk(0, 1, 1,1,8'hE0, 1,0,8'hD2, 1, 0,0, 0,8'h00,0,0), "rstmid_c");
    apply(mk(0, 0, 1,1,8'hE0, 1,0,8'hD2, 1, 1,0, 1,8'hE0,1,0), "rstmid_d");

    // per-beat mode on dut1, both sources always valid
    apply(mk(2, 1, 0,0,8'h00, 0,0,8'h00, 1, 0,0, 0,8'h00,0,0), "pb_rst");
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d0, d1, ed;
      d0 = 8'((i + 1) / 2);
      d1 = 8'h10 + 8'(i / 2);
      ed = (i % 2 == 0) ? d0 : d1;
      apply(mk(1, 0, 1,0,d0, 1,0,d1, 1, (i % 2 == 0), (i % 2 == 1),
               1, ed, 0, (i % 2 == 1)), $sformatf("pb%0d", i));
    end

    // ---------------- random traffic vs model ----------------
    for (int k = 0; k < 2; k++) begin
      m_lock[k] = -1; m_prio[k] = 0;
      m_v[k] = 0; m_d[k] = 0; m_l[k] = 0; m_s[k] = 0;
      for (int x = 0; x < 2; x++) begin rv[k][x] = 0; rl[k][x] = 0; rd[k][x] = 0; end
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int   g[2];
      logic ld[2];
      rst = (cyc < 2) || ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 2; k++) begin
        for (int x = 0; x < 2; x++)
          if (!rv[k][x] && $urandom_range(0, 2) != 0) begin
            rv[k][x] = 1;
            rd[k][x] = 8'($urandom);
            rl[k][x] = ($urandom_range(0, 3) == 0);
          end
        rr[k] = ($urandom_range(0, 3) != 0);
        drv(k, rv[k][0], rl[k][0], rd[k][0], rv[k][1], rl[k][1], rd[k][1], rr[k]);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        ld[k] = !m_v[k] || rr[k];
        g[k]  = -1;
        if (!rst && ld[k]) begin
          if (m_lock[k] >= 0)          g[k] = rv[k][m_lock[k]] ? m_lock[k] : -1;
          else if (rv[k][0] && rv[k][1]) g[k] = m_prio[k];
          else if (rv[k][0])           g[k] = 0;
          else if (rv[k][1])           g[k] = 1;
        end
        chk_rdy(k, "rand", (g[k] == 0), (g[k] == 1));
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_lock[k] = -1; m_prio[k] = 0;
          m_v[k] = 0; m_d[k] = 0; m_l[k] = 0; m_s[k] = 0;
        end else if (ld[k]) begin
          if (g[k] >= 0) begin
            m_v[k] = 1;
            m_d[k] = rd[k][g[k]];
            m_l[k] = rl[k][g[k]];
            m_s[k] = g[k][0];
            if (k == 1 || rl[k][g[k]]) begin
              m_lock[k] = -1;
              m_prio[k] = 1 - g[k];
            end else begin
              m_lock[k] = g[k];
            end
            rv[k][g[k]] = 0;
          end else begin
            m_v[k] = 0;
          end
        end
        chk_out(k, "rand", m_v[k], m_d[k], m_l[k], m_s[k]);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
